// File: rtl/mem_writer_if.sv
// Command channel of the bit-array writer: valid/ready handshake plus the
// opcode and its row/column/data operands.
interface mem_writer_if #(
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_row;
  logic [ADDR_W-1:0] cmd_col;
  logic              cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/mem_writer.sv
// Writer end of the bit-addressed array: owns the N*N bit storage and
// executes handshaked commands one bit per clock.
module mem_writer #(
  parameter int ADDR_W = 2
) (
  input  logic                       _clock,
  input  logic                       _reset,
  mem_writer_if.slave                cmd,
  output logic [(1<<(2*ADDR_W))-1:0] mem,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 wr_count
);

  localparam int NN = 1 << (2*ADDR_W);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {IDLE, EXEC} state_e;

  state_e              state_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   row_q;
  logic [ADDR_W-1:0]   col_q;
  logic                data_q;
  logic [2*ADDR_W-1:0] cursor_q;
  logic [NN-1:0]       mem_q;
  logic                done_q;
  logic [7:0]          wrCount_q;

  logic [2*ADDR_W-1:0] wrIdx_d;
  logic                wrVal_d;
  logic                lastBit_d;
  logic [NN-1:0]       mem_d;
  logic [7:0]          wrCount_d;

  assign cmd.cmd_ready = (state_q == IDLE) && !_reset;
  assign busy          = (state_q == EXEC);
  assign done          = done_q;
  assign mem           = mem_q;
  assign wr_count      = wrCount_q;

  // Bit index is row*N + col, which is just {row, col} because N is a power of two.
  always_comb begin
    wrIdx_d   = {row_q, col_q};
    wrVal_d   = data_q;
    lastBit_d = 1'b1;
    case (op_q)
      OP_WRITE:  wrVal_d = data_q;
      OP_TOGGLE: wrVal_d = ~mem_q[wrIdx_d];
      OP_FILL: begin
        wrIdx_d   = {row_q, cursor_q[ADDR_W-1:0]};
        lastBit_d = &cursor_q[ADDR_W-1:0];
      end
      OP_CLEAR: begin
        wrIdx_d   = cursor_q;
        wrVal_d   = 1'b0;
        lastBit_d = &cursor_q;
      end
      default: wrVal_d = data_q;
    endcase
    mem_d          = mem_q;
    mem_d[wrIdx_d] = wrVal_d;
    wrCount_d      = (wrCount_q == 8'hFF) ? wrCount_q : wrCount_q + 8'd1;
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q   <= IDLE;
      op_q      <= OP_WRITE;
      row_q     <= '0;
      col_q     <= '0;
      data_q    <= 1'b0;
      cursor_q  <= '0;
      mem_q     <= '0;
      done_q    <= 1'b0;
      wrCount_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            op_q     <= cmd.cmd_op;
            row_q    <= cmd.cmd_row;
            col_q    <= cmd.cmd_col;
            data_q   <= cmd.cmd_data;
            cursor_q <= '0;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          mem_q     <= mem_d;
          wrCount_q <= wrCount_d;
          // The cursor stays on the final bit so nothing can land past the target range.
          if (lastBit_d) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cursor_q <= cursor_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: hand-computed mem/handshake/counter values
// for each command type, reset abort and counter saturation.
module tb_mem_writer;

  logic        clock;
  logic        reset;
  logic [15:0] mem;
  logic        busy;
  logic        done;
  logic [7:0]  wrCount;
  int          totalChecks;
  int          badChecks;

  mem_writer_if #(.ADDR_W(2)) bus ();

  mem_writer #(.ADDR_W(2)) dut (
    ._clock   (clock),
    ._reset   (reset),
    .cmd      (bus.slave),
    .mem      (mem),
    .busy     (busy),
    .done     (done),
    .wr_count (wrCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a command, wait for its accept edge, then drop cmd_valid.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] row,
                               input logic [1:0] col, input logic data);
    bus.cmd_op    = op;
    bus.cmd_row   = row;
    bus.cmd_col   = col;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Advance edge by edge until done is seen, bounded.
  task automatic waitDone(input int limit);
    int n;
    n = 0;
    while (n < limit) begin
      @(posedge clock); #1;
      n++;
      if (done) break;
    end
    if (!done) checkOutput("doneTimeout", 32'(n), 32'(limit + 1));
  endtask

  initial begin
    totalChecks   = 0;
    badChecks     = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_row   = 2'd0;
    bus.cmd_col   = 2'd0;
    bus.cmd_data  = 1'b0;
    reset         = 1'b1;

    repeat (2) @(posedge clock);
    #3;
    checkOutput("rstMem", 32'(mem), 32'h0);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    checkOutput("rstDone", 32'(done), 32'h0);
    checkOutput("rstCount", 32'(wrCount), 32'h0);
    checkOutput("rstReady", 32'(bus.cmd_ready), 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("relReady", 32'(bus.cmd_ready), 32'h1);

    // WRITE row 2 col 1 data 1
    applyStimulus(2'b00, 2'd2, 2'd1, 1'b1);
    checkOutput("wrAccBusy", 32'(busy), 32'h1);
    checkOutput("wrAccReady", 32'(bus.cmd_ready), 32'h0);
    @(posedge clock); #1;
    checkOutput("wrMem", 32'(mem), 32'h0200);
    checkOutput("wrDone", 32'(done), 32'h1);
    checkOutput("wrReady", 32'(bus.cmd_ready), 32'h1);
    checkOutput("wrBusy", 32'(busy), 32'h0);
    checkOutput("wrCount", 32'(wrCount), 32'd1);
    @(posedge clock); #1;
    checkOutput("wrDonePulse", 32'(done), 32'h0);

    // FILL_ROW row 3 data 1, with operands scrambled during EXEC
    applyStimulus(2'b01, 2'd3, 2'd0, 1'b1);
    bus.cmd_row  = 2'd0;
    bus.cmd_data = 1'b0;
    bus.cmd_op   = 2'b10;
    @(posedge clock); #1;
    checkOutput("fillE1", 32'(mem), 32'h1200);
    checkOutput("fillBusy1", 32'(busy), 32'h1);
    @(posedge clock); #1;
    checkOutput("fillE2", 32'(mem), 32'h3200);
    @(posedge clock); #1;
    checkOutput("fillE3", 32'(mem), 32'h7200);
    checkOutput("fillBusy3", 32'(busy), 32'h1);
    checkOutput("fillDone3", 32'(done), 32'h0);
    @(posedge clock); #1;
    checkOutput("fillE4", 32'(mem), 32'hF200);
    checkOutput("fillDone", 32'(done), 32'h1);
    checkOutput("fillBusy4", 32'(busy), 32'h0);
    checkOutput("fillCount", 32'(wrCount), 32'd5);

    // Back-to-back TOGGLE row 0 col 0 with cmd_valid held
    bus.cmd_op    = 2'b11;
    bus.cmd_row   = 2'd0;
    bus.cmd_col   = 2'd0;
    bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    checkOutput("tgAcc1", 32'(busy), 32'h1);
    @(posedge clock); #1;
    checkOutput("tgMem1", 32'(mem), 32'hF201);
    checkOutput("tgDone1", 32'(done), 32'h1);
    @(posedge clock); #1;
    checkOutput("tgAcc2", 32'(busy), 32'h1);
    checkOutput("tgDoneOff", 32'(done), 32'h0);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    checkOutput("tgMem2", 32'(mem), 32'hF200);
    checkOutput("tgDone2", 32'(done), 32'h1);
    checkOutput("tgCount", 32'(wrCount), 32'd7);

    // Fill the whole array, clear one bit, then CLEAR_ALL
    for (int r = 0; r < 4; r++) begin
      applyStimulus(2'b01, 2'(r), 2'd0, 1'b1);
      waitDone(10);
    end
    checkOutput("allOnes", 32'(mem), 32'hFFFF);
    applyStimulus(2'b00, 2'd1, 2'd2, 1'b0);
    waitDone(4);
    checkOutput("wrZero", 32'(mem), 32'hFFBF);
    checkOutput("wrZeroCount", 32'(wrCount), 32'd24);
    applyStimulus(2'b10, 2'd3, 2'd3, 1'b1);
    repeat (8) begin @(posedge clock); #1; end
    checkOutput("clrHalf", 32'(mem), 32'hFF00);
    checkOutput("clrHalfBusy", 32'(busy), 32'h1);
    repeat (8) begin @(posedge clock); #1; end
    checkOutput("clrAll", 32'(mem), 32'h0000);
    checkOutput("clrDone", 32'(done), 32'h1);
    checkOutput("clrCount", 32'(wrCount), 32'd40);
    applyStimulus(2'b00, 2'd0, 2'd0, 1'b0);
    waitDone(4);
    checkOutput("sameValMem", 32'(mem), 32'h0000);
    checkOutput("sameValCount", 32'(wrCount), 32'd41);

    // Reset two columns into a FILL_ROW of row 1
    applyStimulus(2'b01, 2'd1, 2'd0, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("abortPre", 32'(mem), 32'h0030);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abortMem", 32'(mem), 32'h0);
    checkOutput("abortBusy", 32'(busy), 32'h0);
    checkOutput("abortDone", 32'(done), 32'h0);
    checkOutput("abortReady", 32'(bus.cmd_ready), 32'h0);
    checkOutput("abortCount", 32'(wrCount), 32'h0);
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("postRstMem", 32'(mem), 32'h0);
    applyStimulus(2'b00, 2'd3, 2'd3, 1'b1);
    @(posedge clock); #1;
    checkOutput("postRstWr", 32'(mem), 32'h8000);
    checkOutput("postRstDone", 32'(done), 32'h1);
    checkOutput("postRstCount", 32'(wrCount), 32'd1);

    // Counter saturation over 20 CLEAR_ALLs
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(2'b10, 2'd0, 2'd0, 1'b0);
      waitDone(20);
      if (i == 15) checkOutput("count15", 32'(wrCount), 32'd241);
      if (i == 16) checkOutput("count16", 32'(wrCount), 32'd255);
    end
    checkOutput("countSat", 32'(wrCount), 32'd255);
    checkOutput("satMem", 32'(mem), 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
